mix_output_controller: RTL and testbench
========================================

// Module: mix_output_controller
// PURPOSE
//   Receiving end of the mix-layer datapath. Captures the full HID_DIM x HID_DIM result block on valid_in.
//   MIX1/MIX2 results: handed back to the mix input controller as one registered full-width word plus a 1-cycle valid_mix pulse.
//   MIX3 results: streamed row by row to the downstream dense stage over a valid/ready handshake.
// PARAMETERS
//   HID_DIM    24   hidden dimension; rows per block and elements per row
//   N          10   sequence length; rows streamed in FORWARD/GEN_SIMI/GEN_NEW
//   N_LEN      16   element width, two's complement fixed point
//   STATE_LEN  (consts_trained.vh)  width of state; encodings MIX1/MIX2/MIX3 from consts_trained.vh
//   MODE_LEN   (consts_trained.vh)  width of mode; encodings FORWARD/BACKWARD/GEN_SIMI/GEN_NEW from consts_trained.vh
// PORTS
//   clk        in   1                   clock, rising edge
//   rst        in   1                   asynchronous reset, active-high
//   state      in   STATE_LEN           top-level state, sampled only on accepted valid_in
//   mode       in   MODE_LEN            run mode, sampled only on accepted valid_in
//   d          in   HID_DIM*HID_DIM*N_LEN  mix-layer result block; row i = d[i*HID_DIM*N_LEN +: HID_DIM*N_LEN]
//   valid_in   in   1                   1-cycle strobe, d valid
//   ready_out  in   1                   downstream accepts q_row this cycle
//   q_mix      out  HID_DIM*HID_DIM*N_LEN  captured block, held until the next accepted capture
//   valid_mix  out  1                   1-cycle pulse: q_mix holds a MIX1/MIX2 result
//   q_row      out  HID_DIM*N_LEN       current streamed row
//   valid_row  out  1                   q_row valid (STREAM state)
//   row_idx    out  $clog2(HID_DIM)     index of q_row
//   done       out  1                   1-cycle pulse after the last row is accepted
//   busy       out  1                   high whenever FSM != IDLE
//   overrun    out  1                   sticky: valid_in arrived while busy
// BEHAVIOUR
//   Reset (async, rst=1): FSM=IDLE; buffer, q_mix, row_idx, lat_state, lat_mode = 0; all outputs 0.
//   FSM states: IDLE, FEEDBACK, STREAM, DONE.
//   IDLE:
//     - valid_in=1 and state in {MIX1, MIX2, MIX3}: latch d into buffer, and state/mode into lat_state/lat_mode.
//     - Next state: FEEDBACK if MIX1/MIX2; STREAM with row_idx=0 if MIX3.
//     - valid_in in any other state: ignored, no latch, FSM stays IDLE.
//   FEEDBACK: valid_mix=1 for exactly this cycle, then IDLE.
//     - Latency: valid_in at edge t -> valid_mix high in cycle t+1, q_mix already updated.
//   STREAM:
//     - valid_row=1; q_row = buffer row row_idx.
//     - Row limit L = HID_DIM if lat_mode==BACKWARD, else N.
//     - On valid_row & ready_out: if row_idx==L-1 go to DONE, else row_idx+1.
//     - ready_out=0: q_row and row_idx held stable, valid_row stays 1 (no retraction).
//     - First valid_row appears in cycle t+1 after capture.
//     - Full handshake throughput: 1 row/cycle.
//   DONE: done=1 for one cycle; row_idx reset to 0; then IDLE.
//     - Next capture accepted at the earliest in the cycle after DONE.
//   valid_in while busy: data dropped, buffer/q_mix untouched, overrun<=1.
//     - overrun is sticky; cleared only by rst.
//   state/mode changes while busy: no effect; lat_state/lat_mode govern the transaction.
//   Reset mid-STREAM or mid-FEEDBACK: immediate return to reset values; no done/valid_mix pulse afterwards.
//   No arithmetic on data: pure buffering and routing, bit-exact.
// TESTING
//   1 MIX1: state=MIX1, one valid_in with d[k*16+:16]=k -> valid_mix exactly 1 cycle at t+1; q_mix==d; valid_row never high.
//   2 MIX3 FORWARD, ready_out=1: d row i filled with 16'h0100+i -> 10 consecutive valid_row beats, row_idx 0..9, q_row = rows 0..9; done at beat 10 end; busy low afterwards.
//   3 MIX3 BACKWARD, ready_out toggling 1,0,1,0 -> 24 beats total; q_row/row_idx stable across every ready_out=0 cycle; done once.
//   4 valid_in during STREAM with different d -> stream unchanged, overrun=1 and stays 1 after done; next IDLE capture works normally.
//   5 valid_in with state=IDLE-class encoding (not MIX1/2/3) -> no latch, busy=0, q_mix unchanged.
//   6 rst asserted at row 5 of a MIX3 stream -> outputs 0 asynchronously, no done; a fresh MIX2 capture afterwards yields valid_mix at t+1.

Source files
------------

// File: rtl/mix_output_controller.sv
// Captures a HID_DIM x HID_DIM mix result: MIX1/MIX2 returned as q_mix with a valid_mix pulse at t+1,
// MIX3 streamed one row/cycle from t+1 over valid/ready; stalled rows are held, never retracted.
module mix_output_controller #(
    parameter int HID_DIM   = 24,
    parameter int N         = 10,
    parameter int N_LEN     = 16,
    parameter int STATE_LEN = 3,
    parameter int MODE_LEN  = 2,
    parameter logic [STATE_LEN-1:0] MIX1     = 3'd1,
    parameter logic [STATE_LEN-1:0] MIX2     = 3'd2,
    parameter logic [STATE_LEN-1:0] MIX3     = 3'd3,
    parameter logic [MODE_LEN-1:0]  BACKWARD = 2'd1,
    localparam int ROW_W = HID_DIM * N_LEN,
    localparam int BLK_W = HID_DIM * ROW_W,
    localparam int IDX_W = $clog2(HID_DIM)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [STATE_LEN-1:0] state,
    input  logic [MODE_LEN-1:0]  mode,
    input  logic [BLK_W-1:0]     d,
    input  logic                 valid_in,
    input  logic                 ready_out,
    output logic [BLK_W-1:0]     q_mix,
    output logic                 valid_mix,
    output logic [ROW_W-1:0]     q_row,
    output logic                 valid_row,
    output logic [IDX_W-1:0]     row_idx,
    output logic                 done,
    output logic                 busy,
    output logic                 overrun
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FEEDBACK,
        S_STREAM,
        S_DONE
    } fsm_t;

    fsm_t fsm, fsm_nxt;

    logic [BLK_W-1:0]    buffer;
    logic [MODE_LEN-1:0] lat_mode;
    logic                is_mix12;
    logic                is_mix3;
    logic                capture;
    logic [IDX_W-1:0]    last_idx;
    logic                last_beat;

    assign is_mix12  = (state == MIX1) || (state == MIX2);
    assign is_mix3   = (state == MIX3);
    assign capture   = valid_in && (fsm == S_IDLE) && (is_mix12 || is_mix3);
    // BACKWARD drains the whole block; every other mode only the N sequence rows
    assign last_idx  = (lat_mode == BACKWARD) ? IDX_W'(HID_DIM - 1) : IDX_W'(N - 1);
    assign last_beat = (fsm == S_STREAM) && ready_out && (row_idx == last_idx);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm <= S_IDLE;
        end else begin
            fsm <= fsm_nxt;
        end
    end

    always_comb begin
        fsm_nxt   = fsm;
        valid_mix = 1'b0;
        valid_row = 1'b0;
        done      = 1'b0;
        busy      = 1'b1;
        unique case (fsm)
            S_IDLE: begin
                busy = 1'b0;
                if (capture) begin
                    fsm_nxt = is_mix3 ? S_STREAM : S_FEEDBACK;
                end
            end
            S_FEEDBACK: begin
                valid_mix = 1'b1;
                fsm_nxt   = S_IDLE;
            end
            S_STREAM: begin
                valid_row = 1'b1;
                if (last_beat) begin
                    fsm_nxt = S_DONE;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                fsm_nxt = S_IDLE;
            end
            default: fsm_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buffer   <= '0;
            lat_mode <= '0;
            row_idx  <= '0;
            overrun  <= 1'b0;
        end else begin
            if (capture) begin
                buffer   <= d;
                lat_mode <= mode;
                row_idx  <= '0;
            end
            if (valid_in && (fsm != S_IDLE)) begin
                overrun <= 1'b1;
            end
            if ((fsm == S_STREAM) && ready_out && !last_beat) begin
                row_idx <= row_idx + 1'b1;
            end
            if (fsm == S_DONE) begin
                row_idx <= '0;
            end
        end
    end

    assign q_mix = buffer;
    assign q_row = valid_row ? buffer[row_idx * ROW_W +: ROW_W] : '0;

endmodule

// File: tb/tb_mix_output_controller.sv
// Random and directed stimulus for mix_output_controller, checked by a queue-based scoreboard.
module tb_mix_output_controller;

    localparam int HID_DIM = 24;
    localparam int N       = 10;
    localparam int N_LEN   = 16;
    localparam int ROW_W   = HID_DIM * N_LEN;
    localparam int BLK_W   = HID_DIM * ROW_W;
    localparam int IDX_W   = 5;
    localparam logic [2:0] MIX1 = 3'd1, MIX2 = 3'd2, MIX3 = 3'd3;
    localparam logic [1:0] FORWARD = 2'd0, BACKWARD = 2'd1;

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic [ROW_W-1:0] dat;
    } row_t;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [2:0]       state = '0;
    logic [1:0]       mode = '0;
    logic [BLK_W-1:0] d = '0;
    logic             valid_in = 1'b0;
    logic             ready_out = 1'b1;
    logic [BLK_W-1:0] q_mix;
    logic             valid_mix;
    logic [ROW_W-1:0] q_row;
    logic             valid_row;
    logic [IDX_W-1:0] row_idx;
    logic             done;
    logic             busy;
    logic             overrun;

    mix_output_controller #(
        .HID_DIM(HID_DIM), .N(N), .N_LEN(N_LEN), .STATE_LEN(3), .MODE_LEN(2),
        .MIX1(MIX1), .MIX2(MIX2), .MIX3(MIX3), .BACKWARD(BACKWARD)
    ) dut (
        .clk(clk), .rst(rst), .state(state), .mode(mode), .d(d),
        .valid_in(valid_in), .ready_out(ready_out), .q_mix(q_mix),
        .valid_mix(valid_mix), .q_row(q_row), .valid_row(valid_row),
        .row_idx(row_idx), .done(done), .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model state
    logic [BLK_W-1:0] exp_mix_q[$];
    row_t             exp_row_q[$];
    int               exp_done = 0;
    logic             exp_overrun = 1'b0;
    logic [BLK_W-1:0] model_blk = '0;
    int               rdy_mode = 0;

    task automatic check(input string nm, input logic [ROW_W-1:0] act, input logic [ROW_W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic check_blk(input string nm, input logic [BLK_W-1:0] act, input logic [BLK_W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got low %h expected low %h", nm, act[127:0], exp[127:0]);
        end
    endtask

    function automatic logic [BLK_W-1:0] rand_blk();
        logic [BLK_W-1:0] b;
        for (int i = 0; i < BLK_W / 32; i++) b[i*32 +: 32] = $urandom;
        return b;
    endfunction

    // A capture either becomes one feedback word or a list of rows followed by one done
    function automatic void model_issue(input logic [2:0] st, input logic [1:0] md,
                                        input logic [BLK_W-1:0] blk, input bit busy_now);
        row_t r;
        int   rows;
        if (busy_now) begin
            exp_overrun = 1'b1;
        end else if (st == MIX1 || st == MIX2) begin
            model_blk = blk;
            exp_mix_q.push_back(blk);
        end else if (st == MIX3) begin
            model_blk = blk;
            rows = (md == BACKWARD) ? HID_DIM : N;
            for (int i = 0; i < rows; i++) begin
                r.idx = IDX_W'(i);
                r.dat = blk[i*ROW_W +: ROW_W];
                exp_row_q.push_back(r);
            end
            exp_done++;
        end
    endfunction

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       ready_out = 1'b1;
            1:       ready_out = ~ready_out;
            default: ready_out = 1'($urandom_range(0, 1));
        endcase
    end

    // Monitor
    logic prev_hold = 1'b0;
    row_t prev_row;
    always @(negedge clk) begin
        row_t er;
        if (rst) begin
            prev_hold = 1'b0;
        end else begin
            check("overrun", ROW_W'(overrun), ROW_W'(exp_overrun));
            if (valid_mix) begin
                if (exp_mix_q.size() == 0) check("unexpected_valid_mix", 1, 0);
                else check_blk("q_mix_feedback", q_mix, exp_mix_q.pop_front());
            end
            if (prev_hold) begin
                check("valid_row_held", ROW_W'(valid_row), 1);
                check("row_idx_held", ROW_W'(row_idx), ROW_W'(prev_row.idx));
                check("q_row_held", q_row, prev_row.dat);
            end
            if (valid_row) begin
                if (ready_out) begin
                    if (exp_row_q.size() == 0) begin
                        check("unexpected_row", 1, 0);
                    end else begin
                        er = exp_row_q.pop_front();
                        check("row_idx", ROW_W'(row_idx), ROW_W'(er.idx));
                        check("q_row", q_row, er.dat);
                    end
                end
                prev_hold = !ready_out;
                prev_row.idx = row_idx;
                prev_row.dat = q_row;
            end else begin
                prev_hold = 1'b0;
            end
            if (done) begin
                if (exp_done == 0) check("unexpected_done", 1, 0);
                else exp_done--;
            end
        end
    end

    task automatic issue(input logic [2:0] st, input logic [1:0] md,
                         input logic [BLK_W-1:0] blk, input bit busy_now);
        state = st; mode = md; d = blk; valid_in = 1'b1;
        @(posedge clk); #1;
        valid_in = 1'b0;
        // later changes of state/mode must not affect the running transaction
        state = 3'($urandom); mode = 2'($urandom); d = rand_blk();
        model_issue(st, md, blk, busy_now);
        if (!busy_now) begin
            if (st == MIX1 || st == MIX2) begin
                check("valid_mix_t1", ROW_W'(valid_mix), 1);
                check_blk("q_mix_t1", q_mix, blk);
            end else if (st == MIX3) begin
                check("valid_row_t1", ROW_W'(valid_row), 1);
                check("row_idx_t1", ROW_W'(row_idx), 0);
                check("q_row_t1", q_row, blk[ROW_W-1:0]);
            end else begin
                check("busy_ignored", ROW_W'(busy), 0);
                check_blk("q_mix_unchanged", q_mix, model_blk);
            end
        end
    endtask

    task automatic wait_idle(output int cyc);
        cyc = 0;
        do begin
            @(posedge clk); #1;
            cyc++;
        end while (busy && cyc < 500);
        if (busy) check("idle_timeout", 1, 0);
        check("rows_left", ROW_W'(exp_row_q.size()), 0);
        check("mix_left", ROW_W'(exp_mix_q.size()), 0);
        check("done_left", ROW_W'(exp_done), 0);
    endtask

    task automatic check_all_zero(input string nm);
        check({nm, "_q_mix"}, ROW_W'(q_mix == '0), 1);
        check({nm, "_outs"}, ROW_W'({valid_mix, valid_row, done, busy, overrun}), 0);
        check({nm, "_row"}, q_row, '0);
        check({nm, "_row_idx"}, ROW_W'(row_idx), 0);
    endtask

    initial begin
        logic [BLK_W-1:0] blk;
        int cyc;
        logic [2:0] st;

        #2 rst = 1'b1;
        #1 check_all_zero("reset");
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk); #1;

        // MIX1 with element k holding k
        for (int k = 0; k < HID_DIM * HID_DIM; k++) blk[k*16 +: 16] = 16'(k);
        issue(MIX1, FORWARD, blk, 0);
        wait_idle(cyc);
        check("mix1_cycles", ROW_W'(cyc), 1);

        // MIX3 FORWARD, ready always high: 10 beats, full throughput
        rdy_mode = 0;
        for (int r = 0; r < HID_DIM; r++)
            for (int e = 0; e < HID_DIM; e++) blk[(r*HID_DIM + e)*16 +: 16] = 16'h0100 + 16'(r);
        issue(MIX3, FORWARD, blk, 0);
        wait_idle(cyc);
        check("fwd_cycles", ROW_W'(cyc), N + 1);

        // MIX3 BACKWARD with toggling ready
        rdy_mode = 1;
        issue(MIX3, BACKWARD, rand_blk(), 0);
        wait_idle(cyc);

        // Capture attempt while streaming is dropped and flags overrun
        issue(MIX3, FORWARD, rand_blk(), 0);
        repeat (3) @(posedge clk);
        #1 issue(MIX3, BACKWARD, rand_blk(), 1);
        wait_idle(cyc);
        check("overrun_after_done", ROW_W'(overrun), 1);
        issue(MIX2, FORWARD, rand_blk(), 0);
        wait_idle(cyc);

        // Non-mix state: ignored
        issue(3'd0, FORWARD, rand_blk(), 0);
        wait_idle(cyc);
        issue(3'd5, BACKWARD, rand_blk(), 0);
        wait_idle(cyc);

        // Randomized transactions
        for (int i = 0; i < 25; i++) begin
            rdy_mode = $urandom_range(0, 2);
            st = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 2) != 0) st = 3'($urandom_range(1, 3));
            issue(st, 2'($urandom), rand_blk(), 0);
            if (st >= MIX1 && st <= MIX3 && $urandom_range(0, 3) == 0)
                issue(3'($urandom_range(1, 3)), 2'($urandom), rand_blk(), 1);
            wait_idle(cyc);
        end

        // Reset in the middle of a stream at row 5
        rdy_mode = 0;
        issue(MIX3, FORWARD, rand_blk(), 0);
        cyc = 0;
        while (row_idx != 5 && cyc < 30) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("reach_row5", ROW_W'(row_idx), 5);
        #1 rst = 1'b1;
        exp_row_q.delete();
        exp_mix_q.delete();
        exp_done = 0;
        exp_overrun = 1'b0;
        model_blk = '0;
        #1 check_all_zero("mid_reset");
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 check("no_done_after_rst", ROW_W'(busy), 0);
        issue(MIX2, BACKWARD, rand_blk(), 0);
        wait_idle(cyc);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
